mem_arbiter: RTL and testbench

- Shares the single 16-bit memory port between two requesters: the CPU control unit (fetch and load/store) and a DMA/loader port.
- Serialises accesses through a small FSM.
- Turns byte stores into read-modify-write sequences, so neither requester has to merge byte lanes itself.
- Sits between the requesters and the memory array; memory has synchronous read (data valid the cycle after the address) and synchronous write.

---
 rtl/mem_arb_pkg.sv | 38 +++
 rtl/mem_arb_pick.sv | 46 ++++
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and byte-lane helpers for the memory port arbiter.
// Counter width bounds STARVE_LIMIT to at most 255.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    MERGE,
    DONE
  } state_t;

  typedef enum logic {
    OWN_CPU,
    OWN_DMA
  } owner_t;

  localparam int STARVE_LIMIT_DEF = 4;
  localparam int CNT_W = 8;

  function automatic logic [15:0] byte_merge(
    input logic [15:0] old,
    input logic [7:0]  b,
    input logic        hi
  );
    return hi ? {b, old[7:0]} : {old[15:8], b};
  endfunction

  function automatic logic [15:0] byte_extract(
    input logic [15:0] w,
    input logic        is_byte,
    input logic        hi
  );
    if (!is_byte) return w;
    return {8'h00, (hi ? w[15:8] : w[7:0])};
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select for the memory arbiter.
// MEM_ARB_ROUND_ROBIN_EN switches starve-counter priority to round robin.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic             i_cpu_req,
  input  logic             i_dma_req,
  input  logic [CNT_W-1:0] i_cnt,
  input  owner_t           i_last,
  output owner_t           o_win,
  output logic [CNT_W-1:0] o_cnt_nxt
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic w_unused_cnt;
  assign w_unused_cnt = ^i_cnt;

  always_comb begin
    o_win     = OWN_CPU;
    o_cnt_nxt = '0;
    if (i_cpu_req && i_dma_req)
      o_win = (i_last == OWN_CPU) ? OWN_DMA : OWN_CPU;
    else if (i_dma_req)
      o_win = OWN_DMA;
  end
`else
  logic w_unused_last;
  assign w_unused_last = (i_last == OWN_DMA);

  always_comb begin
    o_win     = OWN_CPU;
    o_cnt_nxt = i_cnt;
    // DMA wins when alone or once CPU has starved it long enough
    if (i_dma_req &&
        (!i_cpu_req || i_cnt >= CNT_W'(STARVE_LIMIT)))
      o_win = OWN_DMA;
    if (o_win == OWN_DMA)
      o_cnt_nxt = '0;
    else if (i_dma_req)
      o_cnt_nxt = i_cnt + CNT_W'(1);
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: serialises CPU/DMA accesses, merges byte stores.
// Optional MEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_byte,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic              dma_byte,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic [ADDR_W-2:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t              r_state;
  owner_t              r_owner;
  owner_t              r_last;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_we;
  logic                r_byte;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;

  owner_t              w_win;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_any;
  logic                w_dma;
  logic                w_we;
  logic                w_byte;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;

  mem_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .i_cpu_req (cpu_req),
    .i_dma_req (dma_req),
    .i_cnt     (r_cnt),
    .i_last    (r_last),
    .o_win     (w_win),
    .o_cnt_nxt (w_cnt_nxt)
  );

  assign w_any   = cpu_req | dma_req;
  assign w_dma   = (w_win == OWN_DMA);
  assign w_we    = w_dma ? dma_we    : cpu_we;
  assign w_byte  = w_dma ? dma_byte  : cpu_byte;
  assign w_addr  = w_dma ? dma_addr  : cpu_addr;
  assign w_wdata = w_dma ? dma_wdata : cpu_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_owner   <= OWN_CPU;
      r_last    <= OWN_DMA;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_byte    <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          mem_we   <= 1'b0;
          mem_addr <= '0;
          if (w_any) begin
            r_owner   <= w_win;
            r_last    <= w_win;
            r_cnt     <= w_cnt_nxt;
            r_we      <= w_we;
            r_byte    <= w_byte;
            r_addr    <= w_addr;
            r_wdata   <= w_wdata;
            mem_addr  <= w_addr[ADDR_W-1:1];
            mem_we    <= w_we & ~w_byte;
            mem_wdata <= w_wdata;
            r_state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (r_we && !r_byte) begin
            mem_we  <= 1'b0;
            cpu_ack <= (r_owner == OWN_CPU);
            dma_ack <= (r_owner == OWN_DMA);
            r_state <= DONE;
          end else begin
            r_state <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (r_we) begin
            mem_we    <= 1'b1;
            mem_wdata <= byte_merge(mem_rdata,
                                    r_wdata[7:0],
                                    r_addr[0]);
            r_state   <= MERGE;
          end else begin
            cpu_ack <= (r_owner == OWN_CPU);
            dma_ack <= (r_owner == OWN_DMA);
            if (r_owner == OWN_CPU)
              cpu_rdata <= byte_extract(mem_rdata,
                                        r_byte,
                                        r_addr[0]);
            else
              dma_rdata <= byte_extract(mem_rdata,
                                        r_byte,
                                        r_addr[0]);
            r_state <= DONE;
          end
        end
        MERGE: begin
          mem_we  <= 1'b0;
          cpu_ack <= (r_owner == OWN_CPU);
          dma_ack <= (r_owner == OWN_DMA);
          r_state <= DONE;
        end
        DONE: begin
          cpu_ack  <= 1'b0;
          dma_ack  <= 1'b0;
          mem_addr <= '0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table plus
// contention and mid-transaction reset sequences.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_byte;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ack;
  logic        dma_req, dma_we, dma_byte;
  logic [15:0] dma_addr, dma_wdata, dma_rdata;
  logic        dma_ack;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata, mem_rdata;

  logic [15:0] tmem [0:32767];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit          dma;
    bit          we;
    bit          bw;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          lat;
    logic [14:0] maddr;
    logic [15:0] exp;
  } vec_t;

  vec_t vt[13];
  bit   exp_w[10];
  bit   got_w[10];

  mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_byte  (cpu_byte),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_byte  (dma_byte),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_rdata (dma_rdata),
    .dma_ack   (dma_ack),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) tmem[mem_addr] <= mem_wdata;
    mem_rdata <= tmem[mem_addr];
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v, input int idx);
    int          cyc = 0;
    int          wcnt = 0;
    logic [14:0] ia = '0;
    logic [14:0] wa = '0;
    logic [15:0] wd = '0;
    logic [15:0] rd = '0;
    bit          oth = 0;
    bit          got = 0;
    string       p;
    p = $sformatf("v%0d", idx);
    if (v.dma) begin
      dma_we = v.we; dma_byte = v.bw;
      dma_addr = v.addr; dma_wdata = v.wdata;
      dma_req = 1'b1;
    end else begin
      cpu_we = v.we; cpu_byte = v.bw;
      cpu_addr = v.addr; cpu_wdata = v.wdata;
      cpu_req = 1'b1;
    end
    while (!got && cyc < 12) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) ia = mem_addr;
      if (mem_we) begin
        wcnt++; wa = mem_addr; wd = mem_wdata;
      end
      if (v.dma ? cpu_ack : dma_ack) oth = 1;
      if (v.dma ? dma_ack : cpu_ack) begin
        got = 1;
        rd = v.dma ? dma_rdata : cpu_rdata;
      end
    end
    cpu_req = 1'b0;
    dma_req = 1'b0;
    chk({p, "_lat"}, got ? cyc : 99, v.lat);
    chk({p, "_issue_addr"}, {17'd0, ia}, {17'd0, v.maddr});
    chk({p, "_other_ack"}, {31'd0, oth}, 0);
    chk({p, "_we_cnt"}, wcnt, v.we ? 1 : 0);
    if (v.we) begin
      chk({p, "_we_addr"}, {17'd0, wa}, {17'd0, v.maddr});
      chk({p, "_we_data"}, {16'd0, wd}, {16'd0, v.exp});
    end else begin
      chk({p, "_rdata"}, {16'd0, rd}, {16'd0, v.exp});
    end
    @(posedge clk); #1;
    chk({p, "_ack_pulse"},
        {31'd0, (v.dma ? dma_ack : cpu_ack)}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    bit   both;
    bit   seen_ack;
    bit   seen_we;
    vec_t vr;

    vt[0]  = '{1, 1, 0, 16'h0020, 16'hBEEF, 2, 15'h010, 16'hBEEF};
    vt[1]  = '{0, 0, 0, 16'h0020, 16'h0000, 3, 15'h010, 16'hBEEF};
    vt[2]  = '{0, 0, 1, 16'h0021, 16'h0000, 3, 15'h010, 16'h00BE};
    vt[3]  = '{0, 0, 1, 16'h0020, 16'h0000, 3, 15'h010, 16'h00EF};
    vt[4]  = '{1, 1, 0, 16'h0020, 16'h1234, 2, 15'h010, 16'h1234};
    vt[5]  = '{0, 1, 1, 16'h0021, 16'h00AB, 4, 15'h010, 16'hAB34};
    vt[6]  = '{0, 0, 1, 16'h0020, 16'h0000, 3, 15'h010, 16'h0034};
    vt[7]  = '{1, 1, 0, 16'h0100, 16'h5A5A, 2, 15'h080, 16'h5A5A};
    vt[8]  = '{1, 0, 0, 16'h0100, 16'h0000, 3, 15'h080, 16'h5A5A};
    vt[9]  = '{0, 0, 0, 16'h0101, 16'h0000, 3, 15'h080, 16'h5A5A};
    vt[10] = '{1, 1, 1, 16'h0100, 16'h77CD, 4, 15'h080, 16'h5ACD};
    vt[11] = '{1, 0, 0, 16'h0100, 16'h0000, 3, 15'h080, 16'h5ACD};
    vt[12] = '{1, 0, 1, 16'h0101, 16'h0000, 3, 15'h080, 16'h005A};

`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_w = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`else
    exp_w = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`endif

    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_byte = 0;
    cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_byte = 0;
    dma_addr = '0; dma_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_addr", {17'd0, mem_addr}, 0);
    chk("rst_mem_we", {31'd0, mem_we}, 0);
    chk("rst_mem_wdata", {16'd0, mem_wdata}, 0);
    chk("rst_acks", {30'd0, cpu_ack, dma_ack}, 0);
    chk("rst_rdata", {cpu_rdata, dma_rdata}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) run_txn(vt[i], i);

    // both requesters held: record the winner order
    cpu_we = 0; cpu_byte = 0; cpu_addr = 16'h0020;
    dma_we = 0; dma_byte = 0; dma_addr = 16'h0100;
    cpu_req = 1; dma_req = 1;
    n = 0; both = 0;
    for (int c = 0; c < 100 && n < 10; c++) begin
      @(posedge clk); #1;
      if (cpu_ack && dma_ack) both = 1;
      if (cpu_ack) begin
        got_w[n] = 0; n++;
        chk("cont_cpu_rdata", {16'd0, cpu_rdata}, 32'hAB34);
      end else if (dma_ack) begin
        got_w[n] = 1; n++;
        chk("cont_dma_rdata", {16'd0, dma_rdata}, 32'h5ACD);
      end
    end
    cpu_req = 0; dma_req = 0;
    chk("cont_count", n, 10);
    chk("cont_dual_ack", {31'd0, both}, 0);
    for (int i = 0; i < 10; i++)
      chk($sformatf("cont_win%0d", i),
          {31'd0, got_w[i]}, {31'd0, exp_w[i]});
    @(posedge clk); #1;

    // reset lands in CAPTURE of a byte write
    cpu_we = 1; cpu_byte = 1;
    cpu_addr = 16'h0101; cpu_wdata = 16'h0011;
    cpu_req = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_byte = 0;
    chk("mid_rst_mem_addr", {17'd0, mem_addr}, 0);
    chk("mid_rst_mem_we", {31'd0, mem_we}, 0);
    chk("mid_rst_mem_wdata", {16'd0, mem_wdata}, 0);
    chk("mid_rst_acks", {30'd0, cpu_ack, dma_ack}, 0);
    chk("mid_rst_rdata", {cpu_rdata, dma_rdata}, 0);
    seen_ack = 0; seen_we = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (cpu_ack || dma_ack) seen_ack = 1;
      if (mem_we) seen_we = 1;
    end
    chk("mid_rst_no_ack", {31'd0, seen_ack}, 0);
    chk("mid_rst_no_we", {31'd0, seen_we}, 0);
    chk("mid_rst_mem_word", {16'd0, tmem[15'h080]}, 32'h5ACD);

    vr = '{1, 0, 0, 16'h0100, 16'h0000, 3, 15'h080, 16'h5ACD};
    run_txn(vr, 13);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
